// File: rtl/password_check_param_pkg.sv
// Shared state encodings, key indices and width helper for the password lock.
package password_check_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ENTRY = 2'b01,
    ST_ALARM = 2'b10,
    ST_OPEN  = 2'b11
  } state_t;

  localparam int NUM_KEYS    = 5;
  localparam int KEY_EN      = 0;
  localparam int KEY_CONFIRM = 1;
  localparam int KEY_LOCK    = 2;
  localparam int KEY_CHANGE  = 3;
  localparam int KEY_CLR     = 4;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/password_check_param_rise_detect.sv
// Single-bit rising-edge detector; reset preloads history with the live input
// so a level already high across reset never produces an event.
module password_check_param_rise_detect (
  input  logic Clk,
  input  logic Res,
  input  logic d,
  output logic ev
);

  logic d_q_reg;

  always_ff @(posedge Clk) begin
    if (Res) begin
      d_q_reg <= d;
    end else begin
      d_q_reg <= d;
    end
  end

  assign ev = d & ~d_q_reg;

endmodule

// File: rtl/password_check_param.sv
// Password-lock controller: N-digit code entry, error counting with alarm
// lockout, and a stored password that may be replaced while open.
module password_check_param
  import password_check_param_pkg::*;
#(
  parameter int                          DIGITS         = 6,
  parameter int                          DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_PW     = 24'h123456,
  parameter int                          MAX_ERR        = 3,
  parameter int                          LOCKOUT_CYCLES = 8,
  localparam int                         CW             = DIGITS * DIGIT_W,
  localparam int                         EW             = cnt_width(MAX_ERR),
  localparam int                         AW             = cnt_width(LOCKOUT_CYCLES)
) (
  input  logic          Clk,
  input  logic          Res,
  input  logic          En,
  input  logic          Confirm,
  input  logic          Lock,
  input  logic          Change,
  input  logic          Clr,
  input  logic [CW-1:0] in_code,
  output logic [1:0]    status,
  output logic [EW-1:0] ErrCounter,
  output logic [AW-1:0] alarm_left,
  output logic          pw_changed
);

  localparam logic [EW-1:0] MAX_ERR_V = EW'(MAX_ERR);
  localparam logic [AW-1:0] LOCKOUT_V = AW'(LOCKOUT_CYCLES);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] key_ev;

  assign keys = {Clr, Change, Lock, Confirm, En};

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_edge
      password_check_param_rise_detect u_rise (
        .Clk (Clk),
        .Res (Res),
        .d   (keys[gi]),
        .ev  (key_ev[gi])
      );
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [EW-1:0] err_reg, err_next;
  logic [AW-1:0] left_reg, left_next;
  logic [CW-1:0] pw_reg, pw_next;
  logic [CW-1:0] snap_reg, snap_next;
  logic          pw_changed_reg, pw_changed_next;

  always_ff @(posedge Clk) begin
    if (Res) begin
      state_reg      <= ST_IDLE;
      err_reg        <= '0;
      left_reg       <= '0;
      pw_reg         <= DEFAULT_PW;
      snap_reg       <= in_code;
      pw_changed_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      err_reg        <= err_next;
      left_reg       <= left_next;
      pw_reg         <= pw_next;
      snap_reg       <= snap_next;
      pw_changed_reg <= pw_changed_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    err_next        = err_reg;
    left_next       = left_reg;
    pw_next         = pw_reg;
    snap_next       = snap_reg;
    pw_changed_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // The enabling edge only arms the snapshot; entry needs a later code change.
        if (key_ev[KEY_EN]) begin
          snap_next = in_code;
        end else if (En && (in_code != snap_reg)) begin
          state_next = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (!En) begin
          state_next = ST_IDLE;
        end else if (key_ev[KEY_CONFIRM]) begin
          if (in_code == pw_reg) begin
            state_next = ST_OPEN;
            err_next   = '0;
          end else if (err_reg == MAX_ERR_V - 1'b1) begin
            state_next = ST_ALARM;
            err_next   = MAX_ERR_V;
            left_next  = LOCKOUT_V;
          end else begin
            state_next = ST_IDLE;
            err_next   = err_reg + 1'b1;
            snap_next  = in_code;
          end
        end
      end

      ST_OPEN: begin
        if (key_ev[KEY_LOCK]) begin
          state_next = ST_IDLE;
          err_next   = '0;
          snap_next  = in_code;
        end else if (key_ev[KEY_CHANGE]) begin
          pw_next         = in_code;
          pw_changed_next = 1'b1;
        end
      end

      ST_ALARM: begin
        // Admin clear beats the timer; a zero lockout holds until clear or reset.
        if (key_ev[KEY_CLR] || ((LOCKOUT_CYCLES > 0) && (left_reg == ONE_A))) begin
          state_next = ST_IDLE;
          err_next   = '0;
          left_next  = '0;
          snap_next  = in_code;
        end else if (LOCKOUT_CYCLES > 0) begin
          left_next = left_reg - 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign status     = state_reg;
  assign ErrCounter = err_reg;
  assign alarm_left = left_reg;
  assign pw_changed = pw_changed_reg;

endmodule

// File: tb/tb_password_check_param.sv
// Directed plus randomized bench for password_check_param against a
// rule-level reference model of the lock behaviour.
module tb_password_check_param;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_ALARM = 2;
  localparam int M_OPEN  = 3;
  localparam int MAX_ERR = 3;
  localparam int LOCKOUT = 8;
  localparam logic [23:0] DEF_PW = 24'h123456;

  logic        Clk = 1'b0;
  logic        Res;
  logic        En, Confirm, Lock, Change, Clr;
  logic [23:0] in_code;
  logic [1:0]  status;
  logic [1:0]  ErrCounter;
  logic [3:0]  alarm_left;
  logic        pw_changed;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_status, m_err, m_left, m_pwc;
  logic [23:0] m_pw, m_snap;
  bit          p_en, p_conf, p_lock, p_chg, p_clr;

  password_check_param dut (
    .Clk        (Clk),
    .Res        (Res),
    .En         (En),
    .Confirm    (Confirm),
    .Lock       (Lock),
    .Change     (Change),
    .Clr        (Clr),
    .in_code    (in_code),
    .status     (status),
    .ErrCounter (ErrCounter),
    .alarm_left (alarm_left),
    .pw_changed (pw_changed)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_step();
    bit ee, ce, le, che, cle;
    m_pwc = 0;
    if (Res) begin
      m_status = M_IDLE;
      m_err    = 0;
      m_left   = 0;
      m_pw     = DEF_PW;
      m_snap   = in_code;
    end else begin
      ee  = En      && !p_en;
      ce  = Confirm && !p_conf;
      le  = Lock    && !p_lock;
      che = Change  && !p_chg;
      cle = Clr     && !p_clr;
      case (m_status)
        M_IDLE: begin
          if (ee) m_snap = in_code;
          else if (En && in_code != m_snap) m_status = M_ENTRY;
        end
        M_ENTRY: begin
          if (!En) m_status = M_IDLE;
          else if (ce) begin
            if (in_code == m_pw) begin
              m_status = M_OPEN;
              m_err    = 0;
            end else begin
              m_err = m_err + 1;
              if (m_err == MAX_ERR) begin
                m_status = M_ALARM;
                m_left   = LOCKOUT;
              end else begin
                m_status = M_IDLE;
                m_snap   = in_code;
              end
            end
          end
        end
        M_OPEN: begin
          if (le) begin
            m_status = M_IDLE;
            m_err    = 0;
            m_snap   = in_code;
          end else if (che) begin
            m_pw  = in_code;
            m_pwc = 1;
          end
        end
        default: begin
          if (cle || m_left == 1) begin
            m_status = M_IDLE;
            m_err    = 0;
            m_left   = 0;
            m_snap   = in_code;
          end else begin
            m_left = m_left - 1;
          end
        end
      endcase
    end
    p_en   = En;
    p_conf = Confirm;
    p_lock = Lock;
    p_chg  = Change;
    p_clr  = Clr;
  endtask

  task automatic step(input bit en, input bit conf, input bit lock, input bit chg,
                      input bit clr, input logic [23:0] code, input string tag);
    En      = en;
    Confirm = conf;
    Lock    = lock;
    Change  = chg;
    Clr     = clr;
    in_code = code;
    @(posedge Clk);
    model_step();
    #1;
    check({tag, ".status"}, 32'(status), 32'(m_status));
    check({tag, ".err"},    32'(ErrCounter), 32'(m_err));
    check({tag, ".left"},   32'(alarm_left), 32'(m_left));
    check({tag, ".pwc"},    32'(pw_changed), 32'(m_pwc));
    $display("step %-8s t=%0t En=%0b C=%0b L=%0b Ch=%0b Clr=%0b code=%06h -> status=%0d err=%0d left=%0d pwc=%0b",
             tag, $time, en, conf, lock, chg, clr, code, status, ErrCounter, alarm_left, pw_changed);
  endtask

  // One full code attempt from IDLE: arm snapshot, enter code, press Confirm.
  task automatic attempt(input logic [23:0] code, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, code, tag);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, code, tag);
  endtask

  task automatic do_reset(input logic [23:0] code, input bit conf);
    Res = 1'b1;
    step(1'b1, conf, 1'b0, 1'b0, 1'b0, code, "reset");
    Res = 1'b0;
  endtask

  initial begin
    logic [23:0] rcode;
    Res = 1'b1; En = 1'b1; Confirm = 1'b0; Lock = 1'b0; Change = 1'b0; Clr = 1'b0;
    in_code = 24'h0;
    p_en = 1; p_conf = 0; p_lock = 0; p_chg = 0; p_clr = 0;

    // Reset state
    do_reset(24'h000000, 1'b0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_err", 32'(ErrCounter), 32'd0);
    check("rst_left", 32'(alarm_left), 32'd0);

    // 1: correct code opens
    step(1, 0, 0, 0, 0, 24'h123456, "t1_entry");
    check("t1_entry", 32'(status), 32'd1);
    step(1, 1, 0, 0, 0, 24'h123456, "t1_conf");
    check("t1_open", 32'(status), 32'd3);
    check("t1_err", 32'(ErrCounter), 32'd0);
    step(1, 0, 1, 0, 0, 24'h123456, "t1_lock");
    check("t1_locked", 32'(status), 32'd0);

    // 2: three wrong codes then timed lockout
    attempt(24'h111111, "t2_a1");
    check("t2_err1", 32'(ErrCounter), 32'd1);
    check("t2_idle1", 32'(status), 32'd0);
    attempt(24'h111111, "t2_a2");
    check("t2_err2", 32'(ErrCounter), 32'd2);
    attempt(24'h111111, "t2_a3");
    check("t2_alarm", 32'(status), 32'd2);
    check("t2_left8", 32'(alarm_left), 32'd8);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 24'h111111, "t2_wait");
    check("t2_left1", 32'(alarm_left), 32'd1);
    step(1, 0, 0, 0, 0, 24'h111111, "t2_exit");
    check("t2_idle", 32'(status), 32'd0);
    check("t2_err0", 32'(ErrCounter), 32'd0);

    // 3: admin clear during lockout
    attempt(24'h111111, "t3_a1");
    attempt(24'h111111, "t3_a2");
    attempt(24'h111111, "t3_a3");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 24'h111111, "t3_wait");
    check("t3_left5", 32'(alarm_left), 32'd5);
    step(1, 0, 0, 0, 1, 24'h111111, "t3_clr");
    check("t3_idle", 32'(status), 32'd0);
    check("t3_left0", 32'(alarm_left), 32'd0);
    step(1, 0, 0, 0, 0, 24'h111111, "t3_rel");

    // 4: change password, lock, old fails, new opens
    attempt(24'h123456, "t4_open");
    check("t4_open", 32'(status), 32'd3);
    step(1, 0, 0, 0, 0, 24'h654321, "t4_code");
    step(1, 0, 0, 1, 0, 24'h654321, "t4_chg");
    check("t4_pwc1", 32'(pw_changed), 32'd1);
    step(1, 0, 0, 0, 0, 24'h654321, "t4_pwc0");
    check("t4_pwc0", 32'(pw_changed), 32'd0);
    step(1, 0, 1, 0, 0, 24'h654321, "t4_lock");
    check("t4_lock", 32'(status), 32'd0);
    attempt(24'h123456, "t4_old");
    check("t4_olderr", 32'(ErrCounter), 32'd1);
    attempt(24'h654321, "t4_new");
    check("t4_newopen", 32'(status), 32'd3);

    // 5: simultaneous Lock and Change, Lock wins
    do_reset(24'h000000, 1'b0);
    attempt(24'h123456, "t5_open");
    step(1, 0, 1, 1, 0, 24'h999999, "t5_both");
    check("t5_idle", 32'(status), 32'd0);
    check("t5_nopwc", 32'(pw_changed), 32'd0);
    attempt(24'h999999, "t5_999");
    check("t5_999err", 32'(ErrCounter), 32'd1);
    attempt(24'h123456, "t5_old");
    check("t5_oldopen", 32'(status), 32'd3);

    // 6: reset in ENTRY with errors; Confirm held through release
    step(1, 0, 1, 0, 0, 24'h123456, "t6_lock");
    attempt(24'h111111, "t6_a1");
    attempt(24'h111111, "t6_a2");
    step(1, 0, 0, 0, 0, 24'h222222, "t6_entry");
    check("t6_entry", 32'(status), 32'd1);
    check("t6_err2", 32'(ErrCounter), 32'd2);
    do_reset(24'h222222, 1'b1);
    check("t6_rst_st", 32'(status), 32'd0);
    check("t6_rst_err", 32'(ErrCounter), 32'd0);
    step(1, 1, 0, 0, 0, 24'h333333, "t6_hold");
    check("t6_hold", 32'(status), 32'd1);
    step(1, 1, 0, 0, 0, 24'h333333, "t6_hold2");
    check("t6_noev", 32'(ErrCounter), 32'd0);
    check("t6_still", 32'(status), 32'd1);

    // Randomized traffic against the model
    rcode = 24'h0;
    for (int i = 0; i < 600; i++) begin
      int sel;
      Res = ($urandom_range(0, 99) == 0);
      sel = $urandom_range(0, 3);
      if (sel == 0) rcode = m_pw;
      else if (sel == 1) rcode = DEF_PW;
      else if (sel == 2) rcode = 24'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, rcode, "rnd");
    end
    Res = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
